// File: rtl/flappy_game_ctrl_if.sv
// flappy_game_ctrl_if: board-side and bird-FSM-side signals of the game sequencer
interface flappy_game_ctrl_if;
    logic       key_raw;
    logic [7:0] bird_pos;
    logic       bird_dead_in;
    logic [7:0] pipe_col;
    logic       press_out;
    logic       fall_out;
    logic       dead_out;
    logic       bird_rst;
    logic       scroll_tick;
    logic [1:0] game_state;
    logic [3:0] score_tens;
    logic [3:0] score_ones;

    modport master (
        output key_raw, bird_pos, bird_dead_in, pipe_col,
        input  press_out, fall_out, dead_out, bird_rst, scroll_tick,
        input  game_state, score_tens, score_ones
    );

    modport slave (
        input  key_raw, bird_pos, bird_dead_in, pipe_col,
        output press_out, fall_out, dead_out, bird_rst, scroll_tick,
        output game_state, score_tens, score_ones
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: IDLE/PLAY/OVER sequencer, gravity/scroll strobes, collision and BCD score
module flappy_game_ctrl #(
    parameter int FALL_DIV   = 12500000,
    parameter int SCROLL_DIV = 25000000
) (
    input logic           clk,
    input logic           reset,
    flappy_game_ctrl_if.slave bus
);
    localparam int FW = $clog2(FALL_DIV);
    localparam int SW = $clog2(SCROLL_DIV);

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;

    state_t        state_q, state_d;
    logic          key_q;
    logic [FW-1:0] fall_cnt_q, fall_cnt_d;
    logic [SW-1:0] scroll_cnt_q, scroll_cnt_d;
    logic          dead_q, dead_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;

    logic play, press_pulse, fall_end, scroll_end, hit, stay_play, bump, clr;

    always_comb begin
        play        = state_q == PLAY;
        press_pulse = bus.key_raw & ~key_q;
        fall_end    = fall_cnt_q == FW'(FALL_DIV - 1);
        scroll_end  = scroll_cnt_q == SW'(SCROLL_DIV - 1);
        hit         = play & ((|(bus.bird_pos & bus.pipe_col)) | bus.bird_dead_in);
        state_d     = (state_q == IDLE) ? (press_pulse ? PLAY : IDLE) :
                      (state_q == PLAY) ? (hit ? OVER : PLAY) :
                      (state_q == OVER) ? (press_pulse ? IDLE : OVER) : IDLE;
        // counters only run while PLAY persists, so they read 0 on the first OVER cycle
        stay_play    = play & (state_d == PLAY);
        fall_cnt_d   = (stay_play & ~fall_end) ? fall_cnt_q + FW'(1) : '0;
        scroll_cnt_d = (stay_play & ~scroll_end) ? scroll_cnt_q + SW'(1) : '0;
        dead_d       = state_d == OVER;
        clr          = (state_q == IDLE) & press_pulse;
        bump         = play & scroll_end & (|bus.pipe_col) & ~hit & ~(tens_q == 4'd9 && ones_q == 4'd9);
        ones_d       = clr ? 4'd0 : bump ? (ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1) : ones_q;
        tens_d       = clr ? 4'd0 : (bump && ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            key_q        <= 1'b0;
            fall_cnt_q   <= '0;
            scroll_cnt_q <= '0;
            dead_q       <= 1'b0;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            key_q        <= bus.key_raw;
            fall_cnt_q   <= fall_cnt_d;
            scroll_cnt_q <= scroll_cnt_d;
            dead_q       <= dead_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
        end
    end

    assign bus.press_out   = play & press_pulse;
    assign bus.fall_out    = play & fall_end;
    assign bus.scroll_tick = play & scroll_end;
    assign bus.dead_out    = dead_q;
    assign bus.bird_rst    = state_q == IDLE;
    assign bus.game_state  = state_q;
    assign bus.score_tens  = tens_q;
    assign bus.score_ones  = ones_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed checks of the game sequencer with FALL_DIV=4, SCROLL_DIV=6
module tb_flappy_game_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    flappy_game_ctrl_if bus ();
    flappy_game_ctrl #(.FALL_DIV(4), .SCROLL_DIV(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        bus.key_raw = 1'b1;
        step();
        bus.key_raw = 1'b0;
        step();
    endtask

    task automatic wait_ticks(input int n, input string tag);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 1000) begin
            @(negedge clk);
            if (bus.scroll_tick) got++;
            cyc++;
        end
        check(tag, got, n);
        step();
    endtask

    logic [12:0] fall_v, scroll_v;
    int          pc, edges, strobes;
    logic        prev;

    initial begin
        reset = 1'b1;
        bus.key_raw = 1'b0;
        bus.bird_pos = 8'h00;
        bus.bird_dead_in = 1'b0;
        bus.pipe_col = 8'h00;
        step();
        @(negedge clk);
        check("rst_state", bus.game_state, 2'b00);
        check("rst_bird_rst", bus.bird_rst, 1'b1);
        check("rst_dead", bus.dead_out, 1'b0);
        check("rst_score", {bus.score_tens, bus.score_ones}, 8'h00);
        step();
        reset = 1'b0;

        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            strobes += int'(bus.fall_out) + int'(bus.scroll_tick) + int'(bus.press_out);
        end
        check("idle_strobes", strobes, 0);
        check("idle_state", bus.game_state, 2'b00);
        check("idle_score", {bus.score_tens, bus.score_ones}, 8'h00);

        step();
        bus.key_raw = 1'b1;
        @(negedge clk);
        check("start_no_press", bus.press_out, 1'b0);
        pc = 0;
        fall_v = '0;
        scroll_v = '0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 5) bus.key_raw = 1'b0;
            @(negedge clk);
            fall_v[k] = bus.fall_out;
            scroll_v[k] = bus.scroll_tick;
            pc += int'(bus.press_out);
            if (k == 1) begin
                check("play_state", bus.game_state, 2'b01);
                check("play_bird_rst", bus.bird_rst, 1'b0);
            end
        end
        check("fall_times", fall_v, 13'h1110);
        check("scroll_times", scroll_v, 13'h1040);
        check("start_press_cnt", pc, 0);

        pc = 0;
        edges = 0;
        prev = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            bus.key_raw = (c % 5) < 3;
            @(negedge clk);
            pc += int'(bus.press_out);
            if (bus.press_out && !prev) edges++;
            prev = bus.press_out;
        end
        check("press_cycles", pc, 3);
        check("press_edges", edges, 3);
        step();
        bus.key_raw = 1'b0;

        bus.bird_pos = 8'b00001000;
        bus.pipe_col = 8'b11100011;
        wait_ticks(10, "score_tmo");
        check("score_10", {bus.score_tens, bus.score_ones}, 8'h10);
        check("score_state", bus.game_state, 2'b01);

        bus.bird_pos = 8'b00000010;
        bus.pipe_col = 8'b00000011;
        @(negedge clk);
        check("hit_pre_dead", bus.dead_out, 1'b0);
        step();
        check("hit_state", bus.game_state, 2'b10);
        check("hit_dead", bus.dead_out, 1'b1);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            strobes += int'(bus.fall_out) + int'(bus.scroll_tick);
        end
        check("over_strobes", strobes, 0);
        check("over_score", {bus.score_tens, bus.score_ones}, 8'h10);
        check("over_dead_held", bus.dead_out, 1'b1);

        bus.bird_pos = 8'b00001000;
        bus.pipe_col = 8'b11100011;
        step();
        bus.key_raw = 1'b1;
        step();
        bus.key_raw = 1'b0;
        check("over_to_idle", bus.game_state, 2'b00);
        check("idle_score_kept", {bus.score_tens, bus.score_ones}, 8'h10);
        check("idle_dead_clr", bus.dead_out, 1'b0);
        check("idle_bird_rst", bus.bird_rst, 1'b1);
        step();
        bus.key_raw = 1'b1;
        step();
        bus.key_raw = 1'b0;
        check("restart_state", bus.game_state, 2'b01);
        check("restart_score", {bus.score_tens, bus.score_ones}, 8'h00);

        wait_ticks(99, "sat_tmo");
        check("score_99", {bus.score_tens, bus.score_ones}, 8'h99);
        wait_ticks(1, "sat2_tmo");
        check("score_sat", {bus.score_tens, bus.score_ones}, 8'h99);
        check("sat_state", bus.game_state, 2'b01);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_state", bus.game_state, 2'b00);
        check("mid_rst_score", {bus.score_tens, bus.score_ones}, 8'h00);
        check("mid_rst_dead", bus.dead_out, 1'b0);
        check("mid_rst_bird_rst", bus.bird_rst, 1'b1);

        press();
        bus.bird_dead_in = 1'b1;
        @(negedge clk);
        check("fell_pre", bus.game_state, 2'b01);
        step();
        bus.bird_dead_in = 1'b0;
        check("fell_state", bus.game_state, 2'b10);
        check("fell_dead", bus.dead_out, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Game sequencer for the Flappy Bird datapath. It sits between the board inputs (button, pipe field) and the bird position FSM.
- Owns game state IDLE/PLAY/OVER and generates the bird's press and gravity (fall) strobes. Also generates the pipe scroll strobe, so that pipe movement is gated by game state.
- Detects collisions between the bird and pipes, drives the bird's Dead input and keeps a 2-digit BCD score.

Parameters:
FALL_DIV, 12500000, clk cycles per gravity tick (must be >= 2)
SCROLL_DIV, 25000000, clk cycles per pipe-scroll tick (must be >= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
key_raw  input  1  flap button, already synchronised to clk, 1 = pressed
bird_pos  input  8  one-hot bird row from bird FSM (bit0 = bottom); all-zero when the bird is in Lose
bird_dead_in  input  1  bird FSM Bird_dead output (bird fell off the bottom)
pipe_col  input  8  pipe occupancy of the column at the bird's x position, 1 = wall
press_out  output  1  one-cycle flap strobe to the bird FSM Press input
fall_out  output  1  one-cycle gravity strobe to the bird FSM fall input
dead_out  output  1  to the bird FSM Dead input
bird_rst  output  1  reset to the bird FSM (holds the bird at Start)
scroll_tick  output  1  one-cycle strobe to the pipe shifter
game_state  output  2  00 IDLE, 01 PLAY, 10 OVER
score_tens  output  4  BCD tens digit
score_ones  output  4  BCD ones digit

Behaviour:
- Reset (synchronous, active-high) takes effect on the clk edge and overrides everything, including mid-PLAY.
- Values after reset: state IDLE, key_q 0, both dividers 0, dead_out 0, score 00, press_out/fall_out/scroll_tick 0, bird_rst 1.
- Edge detect: key_q is key_raw registered. press_pulse = key_raw & ~key_q (combinational). One pulse per press, however long the key is held.
- press_out = press_pulse when state is PLAY, else 0. The press that starts a game therefore does not flap the bird.
- bird_rst = 1 in IDLE, 0 in PLAY and OVER. In OVER the bird FSM stays in Lose.
- Fall divider:
  - Counts 0..FALL_DIV-1 only in PLAY, wraps to 0; held at 0 in IDLE and OVER.
  - fall_out = 1 in the cycle where the count equals FALL_DIV-1 and state is PLAY.
  - First fall_out comes FALL_DIV cycles after entering PLAY.
- Scroll divider: identical scheme using SCROLL_DIV, driving scroll_tick.
- Collision: hit = PLAY & (|(bird_pos & pipe_col) | bird_dead_in), combinational.
- State transitions (registered):
  - IDLE -> PLAY on press_pulse. Score clears to 00 on this same edge.
  - PLAY -> OVER on hit.
  - OVER -> IDLE on press_pulse. Score is preserved through OVER and IDLE until the next game starts.
  - game_state encoding is fixed; code 11 is unreachable and recovers to IDLE next cycle.
- dead_out is registered:
  - Set on the edge where PLAY -> OVER; held 1 throughout OVER.
  - Cleared on entry to IDLE.
  - Latency: hit in cycle N -> state OVER and dead_out = 1 in cycle N+1.
- Score:
  - Increments when PLAY & scroll_tick & (pipe_col != 0) & ~hit, i.e. the bird survived a pipe column passing.
  - BCD: ones 9 -> 0 with tens+1; saturates at 99 with no wrap.
- Simultaneous events:
  - hit and scroll_tick in the same cycle: no score increment, go to OVER.
  - press_out and fall_out in the same cycle: both asserted; the bird FSM resolves them.
  - press_pulse in the same cycle as hit: PLAY -> OVER has priority; press_out is still 1 that cycle, and it is harmless because Dead wins in the bird FSM.
- Every strobe is exactly 1 cycle wide and is never asserted outside PLAY.

Test Plan:
Bench uses FALL_DIV=4 and SCROLL_DIV=6.
- Reset then idle 10 cycles -> game_state=00, bird_rst=1, fall_out/scroll_tick/press_out never 1, score 00.
- key_raw high for 5 cycles in IDLE:
  - -> one transition to PLAY, press_out stays 0, bird_rst drops.
  - fall_out pulses at cycles 4, 8, 12 after entry; scroll_tick at 6, 12.
- In PLAY, key_raw pulsed 3 times, each held 3 cycles -> exactly 3 single-cycle press_out pulses.
- pipe_col=8'b11100011 with bird_pos=8'b00001000, 10 scroll_ticks -> score 10 (tens=1, ones=0), state stays PLAY.
- bird_pos=8'b00000010 with pipe_col=8'b00000011 -> dead_out=1 and game_state=10 next cycle; then scroll_tick and fall_out stay 0 for 20 cycles and the score is frozen.
- Preload score 99 via 99 survived scrolls, then one more -> score stays 99. Then:
  - Assert reset mid-PLAY -> next cycle IDLE, score 00, dead_out 0.
  - In OVER, press -> IDLE with score kept; press again -> PLAY with score 00.
